debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter STABLE, default 20, consecutive mismatch cycles required before an output changes (2..1023).
REQ-003 Localparam CNT_W = $clog2(STABLE), counter width per channel.
REQ-004 clk  input  1  rising-edge clock for all logic.
REQ-005 rstv  input  1  asynchronous, active-high reset; clears all state immediately.
REQ-006 en  input  1  count enable; low freezes all counters, synchronizers keep running.
REQ-007 inv  input  N_CH  raw asynchronous switch/key levels, one bit per channel.
REQ-008 outv  output  N_CH  debounced levels, registered.
REQ-009 rise  output  N_CH  one-cycle pulse per channel when outv bit goes 0->1, registered.
REQ-010 fall  output  N_CH  one-cycle pulse per channel when outv bit goes 1->0, registered.
REQ-011 busy  output  N_CH  per channel, high while that channel's counter is nonzero.
REQ-012 any_change  output  1  registered OR of all rise and fall bits for the same cycle.

Function
REQ-013 Each channel SHALL pass inv[i] through a two-flop synchronizer (s1, s2); logic uses s2 only.
REQ-014 On each edge with en=1 and s2 != outv[i], the channel counter SHALL increment by 1.
REQ-015 On each edge with s2 == outv[i], the counter SHALL clear to 0 regardless of en (bounce discards progress).
REQ-016 On an edge with en=1, s2 != outv[i] and counter == STABLE-1, outv[i] SHALL load s2, the counter SHALL clear to 0, and rise[i] or fall[i] SHALL assert for exactly that following cycle.
REQ-017 Latency: a clean inv[i] change set up before edge e1 SHALL appear on outv[i] after edge e(2+STABLE) (22 edges at default).
REQ-018 With en=0 and a mismatch, counter SHALL hold its value; resuming en continues from the held value.
REQ-019 Counter SHALL never exceed STABLE-1; no wrap-around is possible.
REQ-020 rise and fall for one channel SHALL never assert in the same cycle; channels are fully independent.
REQ-021 busy[i] SHALL equal (counter != 0) from registered state, no combinational path from inv.
REQ-022 Pulses on different channels in the same cycle SHALL all assert; any_change asserts once for that cycle.

Reset
REQ-023 While rstv=1: s1, s2, counters, outv, rise, fall, busy, any_change SHALL all be 0.
REQ-024 Reset asserted mid-count SHALL discard progress; after release a held-high inv SHALL produce rise after 2+STABLE edges.
REQ-025 First edge after rstv deassertion SHALL be treated as normal operation; no pulse is generated by reset release itself.

Structure
REQ-026 Shared package/header debounce_pkg SHALL hold the STABLE default and the CNT_W derivation.
REQ-027 One sub-module debounce_ch (synchronizer, counter, level/pulse logic for one bit) SHALL be instantiated N_CH times via generate; top adds only the any_change OR.

Verification
REQ-028 inv[0] 0->1 clean, en=1, STABLE=20 -> outv[0]=1 and rise[0]=1 for one cycle after edge 22; busy[0] high edges 3..21.
REQ-029 inv[1] toggles every 5 cycles for 100 cycles, then holds 1 -> no pulses during toggling; rise[1] 22 edges after final change.
REQ-030 inv[2] 1->0 stable, en dropped after edge 10 for 7 cycles -> counter holds at 8; fall[2] after edge 29.
REQ-031 rstv pulsed mid-count on channel 3 at edge 12 -> all outputs 0 immediately (asynchronously); full 22-edge delay restarts.
REQ-032 inv all channels 0->1 same cycle -> rise=4'b1111 for one cycle, any_change=1 for one cycle only.
REQ-033 STABLE=2, N_CH=1 build -> output follows a clean change after 4 edges; single-cycle glitch never propagates.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared debounce defaults and per-channel counter width derivation
package debounce_pkg;
   localparam int N_CH_DEF   = 4;
   localparam int STABLE_DEF = 20;
   function automatic int cnt_w(input int stable);
      return $clog2(stable);
   endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel -- two-flop synchronizer, mismatch counter, debounced level and edge pulses
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int STABLE = STABLE_DEF
) (
   input  logic clk,
   input  logic rstv,
   input  logic en,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);
   localparam int CNT_W = cnt_w(STABLE);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);
   logic s1_q, s1_d, s2_q, s2_d;
   logic out_q, out_d, rise_q, rise_d, fall_q, fall_d;
   logic mis, load;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // any cycle where the synced input agrees with the output throws away progress, even with en low
   always_comb begin
      s1_d   = din;
      s2_d   = s1_q;
      mis    = s2_q != out_q;
      load   = en && mis && cnt_q == LAST;
      cnt_d  = (!mis || load) ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
      out_d  = load ? s2_q : out_q;
      rise_d = load && s2_q;
      fall_d = load && !s2_q;
   end
   always_ff @(posedge clk or posedge rstv) begin
      if (rstv) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         cnt_q  <= '0;
         out_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end
   assign dout = out_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = |cnt_q;
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debounce channels plus a combined change flag
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int N_CH   = N_CH_DEF,
   parameter int STABLE = STABLE_DEF
) (
   input  logic            clk,
   input  logic            rstv,
   input  logic            en,
   input  logic [N_CH-1:0] inv,
   output logic [N_CH-1:0] outv,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] busy,
   output logic            any_change
);
   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_ch
         debounce_ch #(.STABLE(STABLE)) u_ch (
            .clk  (clk),
            .rstv (rstv),
            .en   (en),
            .din  (inv[i]),
            .dout (outv[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .busy (busy[i])
         );
      end
   endgenerate
   // built only from registered pulse flops, so it lines up with rise/fall
   assign any_change = |(rise | fall);
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: vector table, corner-case sequences and randomized run against a behavioural model
module tb_debounce_bank;
   localparam int N  = 4;
   localparam int ST = 20;

   logic clk = 1'b0;
   logic rstv = 1'b1;
   logic en = 1'b1;
   logic [N-1:0] inv = '0;
   logic [N-1:0] outv, rise, fall, busy;
   logic any_change;
   logic [0:0] inv2 = '0;
   logic [0:0] outv2, rise2, fall2, busy2;
   logic any2;

   debounce_bank #(.N_CH(N), .STABLE(ST)) dut (
      .clk(clk), .rstv(rstv), .en(en), .inv(inv), .outv(outv),
      .rise(rise), .fall(fall), .busy(busy), .any_change(any_change));

   debounce_bank #(.N_CH(1), .STABLE(2)) dut2 (
      .clk(clk), .rstv(rstv), .en(en), .inv(inv2), .outv(outv2),
      .rise(rise2), .fall(fall2), .busy(busy2), .any_change(any2));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: channels 0..3 belong to dut (STABLE=20), channel 4 to dut2 (STABLE=2).
   // An output flips once the synced input has disagreed with it on STABLE enabled
   // edges with no agreeing edge in between.
   bit m_s1[5], m_s2[5], m_out[5], m_rise[5], m_fall[5];
   int m_prog[5];

   function automatic int stable_of(input int c);
      return c < 4 ? ST : 2;
   endfunction

   always @(posedge clk or posedge rstv) begin
      if (rstv) begin
         for (int c = 0; c < 5; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0;
            m_rise[c] = 0; m_fall[c] = 0; m_prog[c] = 0;
         end
      end else begin
         for (int c = 0; c < 5; c++) begin
            m_rise[c] = 0;
            m_fall[c] = 0;
            if (m_s2[c] == m_out[c]) m_prog[c] = 0;
            else if (en) begin
               m_prog[c] = m_prog[c] + 1;
               if (m_prog[c] == stable_of(c)) begin
                  m_out[c] = m_s2[c];
                  m_prog[c] = 0;
                  if (m_s2[c]) m_rise[c] = 1; else m_fall[c] = 1;
               end
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = (c < 4) ? inv[c] : inv2[0];
         end
      end
   end

   task automatic check_model(input int cyc);
      logic [3:0] eo, er, ef, eb;
      for (int c = 0; c < 4; c++) begin
         eo[c] = m_out[c]; er[c] = m_rise[c]; ef[c] = m_fall[c]; eb[c] = m_prog[c] != 0;
      end
      check($sformatf("rand_bank%0d", cyc), {outv, rise, fall, busy, any_change},
            {eo, er, ef, eb, |(er | ef)});
      check($sformatf("rand_one%0d", cyc), {outv2, rise2, fall2, busy2, any2},
            {m_out[4], m_rise[4], m_fall[4], m_prog[4] != 0, m_rise[4] | m_fall[4]});
   endtask

   task automatic do_reset();
      rstv = 1'b1;
      inv = '0;
      inv2 = '0;
      en = 1'b1;
      @(negedge clk);
      rstv = 1'b0;
   endtask

   typedef struct {
      bit rst;
      logic [3:0] inv;
      bit en;
      int edges;
      logic [3:0] outv, rise, fall, busy;
      bit any;
   } vec_t;

   vec_t tbl[18];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 4'b0001, 1'b1, 2,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tbl[1]  = '{1'b0, 4'b0001, 1'b1, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0};
      tbl[2]  = '{1'b0, 4'b0001, 1'b1, 18, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0};
      tbl[3]  = '{1'b0, 4'b0001, 1'b1, 1,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1};
      tbl[4]  = '{1'b0, 4'b0001, 1'b1, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tbl[5]  = '{1'b1, 4'b1111, 1'b1, 21, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0};
      tbl[6]  = '{1'b0, 4'b1111, 1'b1, 1,  4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1};
      tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1,  4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tbl[8]  = '{1'b0, 4'b0000, 1'b1, 22, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1};
      tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tbl[10] = '{1'b1, 4'b1111, 1'b1, 22, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1};
      tbl[11] = '{1'b0, 4'b1011, 1'b1, 10, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
      tbl[12] = '{1'b0, 4'b1011, 1'b0, 7,  4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
      tbl[13] = '{1'b0, 4'b1011, 1'b1, 11, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
      tbl[14] = '{1'b0, 4'b1011, 1'b1, 1,  4'b1011, 4'b0000, 4'b0100, 4'b0000, 1'b1};
      tbl[15] = '{1'b0, 4'b1111, 1'b1, 5,  4'b1011, 4'b0000, 4'b0000, 4'b0100, 1'b0};
      tbl[16] = '{1'b0, 4'b1011, 1'b0, 3,  4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tbl[17] = '{1'b0, 4'b1011, 1'b1, 3,  4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b0};

      @(negedge clk);
      check("reset_state", {outv, rise, fall, busy, any_change, outv2, busy2}, '0);

      for (int r = 0; r < 18; r++) begin
         if (tbl[r].rst) do_reset();
         inv = tbl[r].inv;
         en = tbl[r].en;
         repeat (tbl[r].edges) @(posedge clk);
         @(negedge clk);
         check($sformatf("row%0d", r), {outv, rise, fall, busy, any_change},
               {tbl[r].outv, tbl[r].rise, tbl[r].fall, tbl[r].busy, tbl[r].any});
      end

      // channel 1 chatters with a 10-cycle period, then settles high
      do_reset();
      for (int k = 0; k < 100; k++) begin
         inv[1] = ((k / 5) % 2) == 1;
         @(posedge clk);
         @(negedge clk);
         check("toggle_no_pulse", {rise, fall}, '0);
      end
      repeat (16) @(posedge clk);
      @(negedge clk);
      check("toggle_pre", {outv[1], rise[1]}, 2'b00);
      @(posedge clk);
      @(negedge clk);
      check("toggle_rise", {outv[1], rise[1]}, 2'b11);

      // asynchronous reset mid-count on channel 3
      do_reset();
      inv = 4'b0111;
      repeat (22) @(posedge clk);
      @(negedge clk);
      inv = 4'b1111;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("midcount", {outv, busy}, {4'b0111, 4'b1000});
      #2 rstv = 1'b1;
      #1 check("async_clear", {outv, rise, fall, busy, any_change}, '0);
      @(negedge clk);
      rstv = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("release_no_pulse", {rise, fall, any_change}, '0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("restart_pre", {outv, rise}, '0);
      @(posedge clk);
      @(negedge clk);
      check("restart_rise", {outv, rise, any_change}, {4'b1111, 4'b1111, 1'b1});

      // short-filter instance: clean change and a single-cycle glitch
      do_reset();
      inv2 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("st2_pre", {outv2, rise2}, 2'b00);
      @(posedge clk);
      @(negedge clk);
      check("st2_rise", {outv2, rise2}, 2'b11);
      repeat (3) @(posedge clk);
      @(negedge clk);
      inv2 = 1'b0;
      @(negedge clk);
      inv2 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("st2_glitch", {outv2, fall2}, 2'b10);
      end

      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 29) == 0) inv[c] = ~inv[c];
         if ($urandom_range(0, 19) == 0) inv2 = ~inv2;
         en = $urandom_range(0, 7) != 0;
         rstv = $urandom_range(0, 1999) == 0;
         @(posedge clk);
         @(negedge clk);
         check_model(cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
